// File: rtl/plru_pkg.sv
// Shared types and tree helpers for the pseudo-LRU set array.
// Trees are handled at a fixed maximum width so one function serves any NUM_WAYS.
package plru_pkg;

    localparam int unsigned PLRU_MAX_WAYS  = 64;
    localparam int unsigned PLRU_MAX_LVL   = 6;
    localparam int unsigned PLRU_MAX_NODES = PLRU_MAX_WAYS - 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } flush_state_e;

    function automatic int unsigned plru_levels(input int unsigned num_ways);
        int unsigned lv;
        lv = 0;
        for (int unsigned k = 0; k <= PLRU_MAX_LVL; k++) begin
            if ((32'd1 << k) < num_ways) lv = k + 1;
        end
        return lv;
    endfunction

    // Point every node on the path to 'way' away from it (MSB selects at the root).
    function automatic logic [PLRU_MAX_NODES-1:0] plru_path_update(
        input logic [PLRU_MAX_NODES-1:0] tree,
        input int unsigned               way,
        input int unsigned               num_ways
    );
        logic [PLRU_MAX_NODES-1:0] t;
        int unsigned               node;
        int unsigned               lv;
        logic                      b;
        t    = tree;
        node = 0;
        lv   = plru_levels(num_ways);
        for (int unsigned l = 0; l < PLRU_MAX_LVL; l++) begin
            if (l < lv) begin
                b       = ((way >> (lv - 1 - l)) & 32'd1) != 0;
                t[node] = ~b;
                node    = 2 * node + 1 + (b ? 32'd1 : 32'd0);
            end
        end
        return t;
    endfunction

    function automatic logic [PLRU_MAX_WAYS-1:0] plru_subtree_mask(
        input int unsigned node,
        input int unsigned num_ways
    );
        logic [PLRU_MAX_WAYS-1:0] m;
        int unsigned              depth;
        int unsigned              pos;
        int unsigned              span;
        depth = 0;
        for (int unsigned k = 1; k <= PLRU_MAX_LVL; k++) begin
            if (node + 1 >= (32'd1 << k)) depth = k;
        end
        pos  = node + 1 - (32'd1 << depth);
        span = num_ways >> depth;
        for (int unsigned i = 0; i < PLRU_MAX_WAYS; i++) begin
            m[i] = (i >= pos * span) && (i < (pos + 1) * span);
        end
        return m;
    endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Combinational lock-aware PLRU victim walk over one tree.
// A locked-out subtree is skipped in favour of its sibling at every level.
module plru_victim_sel
    import plru_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 8,
    localparam int unsigned WayIdxW = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] i_tree,
    input  logic [NUM_WAYS-1:0] i_lock,
    output logic [WayIdxW-1:0]  o_way,
    output logic [NUM_WAYS-1:0] o_oh,
    output logic                o_none
);

    logic [PLRU_MAX_WAYS-1:0] w_free;
    logic [PLRU_MAX_WAYS-1:0] w_lo_mask;
    logic [PLRU_MAX_WAYS-1:0] w_hi_mask;
    logic [WayIdxW-1:0]       w_path;
    int unsigned              w_node;
    logic                     w_dir;

    always_comb begin
        w_free    = PLRU_MAX_WAYS'(~i_lock);
        w_lo_mask = '0;
        w_hi_mask = '0;
        w_path    = '0;
        w_node    = 0;
        w_dir     = 1'b0;
        for (int unsigned lvl = 0; lvl < WayIdxW; lvl++) begin
            w_lo_mask = plru_subtree_mask(2 * w_node + 1, NUM_WAYS);
            w_hi_mask = plru_subtree_mask(2 * w_node + 2, NUM_WAYS);
            w_dir     = i_tree[w_node];
            if (!w_dir && !(|(w_lo_mask & w_free))) begin
                w_dir = 1'b1;
            end else if (w_dir && !(|(w_hi_mask & w_free))) begin
                w_dir = 1'b0;
            end
            w_path = (w_path << 1) | WayIdxW'(w_dir);
            w_node = 2 * w_node + 1 + 32'(w_dir);
        end
    end

    assign o_none = &i_lock;
    assign o_way  = o_none ? '0 : w_path;
    assign o_oh   = o_none ? '0 : (NUM_WAYS'(1) << w_path);

endmodule

// File: rtl/plru_set_array.sv
// Multi-set tree pseudo-LRU engine: hit/fill updates, locked victim lookup, flush sweep.
// Define COMMON_CELLS_PLRU_AUTO_TOUCH_EN to have accepted lookups touch their victim way.
module plru_set_array
    import plru_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 8,
    parameter int unsigned NUM_SETS = 16,
    localparam int unsigned WayIdxW = $clog2(NUM_WAYS),
    localparam int unsigned SetIdxW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                flush_busy_o,
    input  logic                upd_valid_i,
    input  logic [SetIdxW-1:0]  upd_set_i,
    input  logic [WayIdxW-1:0]  upd_way_i,
    input  logic                lkp_valid_i,
    output logic                lkp_ready_o,
    input  logic [SetIdxW-1:0]  lkp_set_i,
    input  logic [NUM_WAYS-1:0] lkp_lock_i,
    output logic                victim_valid_o,
    input  logic                victim_ready_i,
    output logic [WayIdxW-1:0]  victim_way_o,
    output logic [NUM_WAYS-1:0] victim_oh_o,
    output logic                victim_none_o
);

    typedef logic [NUM_WAYS-2:0] tree_t;
    localparam logic [SetIdxW:0] SetLimit = (SetIdxW + 1)'(NUM_SETS);

    tree_t                     r_tree [NUM_SETS];
    flush_state_e              r_state;
    flush_state_e              w_state_nxt;
    logic [SetIdxW-1:0]        r_cnt;
    logic [SetIdxW-1:0]        w_cnt_nxt;
    logic                      w_sweep;

    logic                      r_vld;
    logic [WayIdxW-1:0]        r_way;
    logic [NUM_WAYS-1:0]       r_oh;
    logic                      r_none;

    logic                      w_upd_in_range;
    logic                      w_lkp_in_range;
    logic [SetIdxW-1:0]        w_upd_set;
    logic [SetIdxW-1:0]        w_lkp_set;
    logic                      w_upd_ok;
    logic                      w_lkp_fire;
    logic [PLRU_MAX_NODES-1:0] w_upd_full;
    tree_t                     w_upd_tree;
    tree_t                     w_lkp_tree;
    logic [WayIdxW-1:0]        w_vic_way;
    logic [NUM_WAYS-1:0]       w_vic_oh;
    logic                      w_vic_none;
    logic                      w_touch;
    tree_t                     w_touch_tree;

    // Out-of-range indices collapse to set 0 so the array is never read out of bounds.
    assign w_upd_in_range = {1'b0, upd_set_i} < SetLimit;
    assign w_lkp_in_range = {1'b0, lkp_set_i} < SetLimit;
    assign w_upd_set      = w_upd_in_range ? upd_set_i : '0;
    assign w_lkp_set      = w_lkp_in_range ? lkp_set_i : '0;
    assign w_sweep        = (r_state == SWEEP);
    assign w_upd_ok       = upd_valid_i && w_upd_in_range && !w_sweep;

    assign flush_busy_o   = w_sweep;
    assign lkp_ready_o    = !w_sweep && (!r_vld || victim_ready_i);
    assign w_lkp_fire     = lkp_valid_i && lkp_ready_o;

    always_comb begin
        w_upd_full = plru_path_update(PLRU_MAX_NODES'(r_tree[w_upd_set]),
                                      32'(upd_way_i), NUM_WAYS);
        w_upd_tree = w_upd_full[NUM_WAYS-2:0];
        // Bypass so a lookup sees an update landing on its set in the same cycle.
        if (w_upd_ok && (w_upd_set == w_lkp_set)) begin
            w_lkp_tree = w_upd_tree;
        end else begin
            w_lkp_tree = r_tree[w_lkp_set];
        end
    end

    plru_victim_sel #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_sel (
        .i_tree (w_lkp_tree),
        .i_lock (lkp_lock_i),
        .o_way  (w_vic_way),
        .o_oh   (w_vic_oh),
        .o_none (w_vic_none)
    );

`ifdef COMMON_CELLS_PLRU_AUTO_TOUCH_EN
    logic [PLRU_MAX_NODES-1:0] w_touch_full;
    // Built on the bypassed tree, so the touch overrides the explicit update on shared nodes.
    assign w_touch_full = plru_path_update(PLRU_MAX_NODES'(w_lkp_tree),
                                           32'(w_vic_way), NUM_WAYS);
    assign w_touch_tree = w_touch_full[NUM_WAYS-2:0];
    assign w_touch      = w_lkp_fire && !w_vic_none;
`else
    assign w_touch_tree = w_lkp_tree;
    assign w_touch      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_tree[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (w_sweep && (r_cnt == SetIdxW'(s))) begin
                    r_tree[s] <= '0;
                end else if (w_touch && (w_lkp_set == SetIdxW'(s))) begin
                    r_tree[s] <= w_touch_tree;
                end else if (w_upd_ok && (w_upd_set == SetIdxW'(s))) begin
                    r_tree[s] <= w_upd_tree;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (flush_i) begin
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                if (r_cnt == SetIdxW'(NUM_SETS - 1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // One-entry result buffer; contents hold while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld  <= 1'b0;
            r_way  <= '0;
            r_oh   <= '0;
            r_none <= 1'b0;
        end else if (w_lkp_fire) begin
            r_vld  <= 1'b1;
            r_way  <= w_vic_way;
            r_oh   <= w_vic_oh;
            r_none <= w_vic_none;
        end else if (victim_ready_i) begin
            r_vld  <= 1'b0;
        end
    end

    assign victim_valid_o = r_vld;
    assign victim_way_o   = r_way;
    assign victim_oh_o    = r_oh;
    assign victim_none_o  = r_none;

`ifndef SYNTHESIS
    a_upd_set_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        upd_valid_i |-> w_upd_in_range)
        else $error("plru_set_array: upd_set_i out of range");
    a_lkp_set_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        lkp_valid_i |-> w_lkp_in_range)
        else $error("plru_set_array: lkp_set_i out of range");
`endif

endmodule

// File: tb/tb_plru_set_array.sv
// Self-checking bench for plru_set_array (NUM_WAYS=4, NUM_SETS=8) with a reference tree model.
// Build with COMMON_CELLS_PLRU_AUTO_TOUCH_EN to check the auto-touch variant.
module tb_plru_set_array;

    localparam int NW = 4;
    localparam int NS = 8;
    localparam int WW = 2;
    localparam int SW = 3;
    localparam int RW = 1 + NW + WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          flush_busy_o;
    logic          upd_v = 1'b0;
    logic [SW-1:0] upd_set = '0;
    logic [WW-1:0] upd_way = '0;
    logic          lkp_v = 1'b0;
    logic          lkp_ready_o;
    logic [SW-1:0] lkp_set = '0;
    logic [NW-1:0] lock = '0;
    logic          victim_valid_o;
    logic          vic_rdy = 1'b1;
    logic [WW-1:0] victim_way_o;
    logic [NW-1:0] victim_oh_o;
    logic          victim_none_o;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;

    logic [RW-1:0] exp_q[$];
    logic [2:0]    m_tree [NS];
    int            m_left;

    always #5 clk = ~clk;

    plru_set_array #(
        .NUM_WAYS (NW),
        .NUM_SETS (NS)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .flush_busy_o   (flush_busy_o),
        .upd_valid_i    (upd_v),
        .upd_set_i      (upd_set),
        .upd_way_i      (upd_way),
        .lkp_valid_i    (lkp_v),
        .lkp_ready_o    (lkp_ready_o),
        .lkp_set_i      (lkp_set),
        .lkp_lock_i     (lock),
        .victim_valid_o (victim_valid_o),
        .victim_ready_i (vic_rdy),
        .victim_way_o   (victim_way_o),
        .victim_oh_o    (victim_oh_o),
        .victim_none_o  (victim_none_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Node 0 = root, node 1 = ways 0/1, node 2 = ways 2/3; bit 1 points to the upper half.
    function automatic logic [2:0] m_upd(input logic [2:0] t, input logic [1:0] w);
        logic [2:0] r;
        r    = t;
        r[0] = ~w[1];
        if (w[1]) r[2] = ~w[0];
        else      r[1] = ~w[0];
        return r;
    endfunction

    function automatic logic [RW-1:0] m_victim(input logic [2:0] t, input logic [3:0] lk);
        logic       h;
        logic       l;
        logic [1:0] w;
        logic [3:0] oh;
        if (lk == 4'hF) return {1'b1, 4'b0000, 2'b00};
        h = t[0];
        if (!h && lk[0] && lk[1])      h = 1'b1;
        else if (h && lk[2] && lk[3])  h = 1'b0;
        l = h ? t[2] : t[1];
        w = {h, l};
        if (lk[w]) l = ~l;
        w  = {h, l};
        oh = 4'b0001 << w;
        return {1'b0, oh, w};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_tree[s] = 3'b000;
        m_left = 0;
        exp_q.delete();
    endtask

    // One clock: check outputs against the model, advance the model, step to next negedge.
    task automatic cycle();
        bit            busy;
        bit            exp_rdy;
        bit            fire;
        bit            upd_ok;
        logic [2:0]    t;
        logic [RW-1:0] v;
        #1;
        busy    = (m_left > 0);
        exp_rdy = !busy && ((exp_q.size() == 0) || vic_rdy);
        check("flush_busy", 32'(flush_busy_o), 32'(busy));
        check("lkp_ready", 32'(lkp_ready_o), 32'(exp_rdy));
        check("victim_valid", 32'(victim_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("victim", 32'({victim_none_o, victim_oh_o, victim_way_o}), 32'(exp_q[0]));
            if (vic_rdy) void'(exp_q.pop_front());
        end
        fire   = lkp_v && exp_rdy;
        upd_ok = upd_v && !busy;
        t      = m_tree[lkp_set];
        v      = '0;
        if (fire) begin
            if (upd_ok && (upd_set == lkp_set)) t = m_upd(t, upd_way);
            v = m_victim(t, lock);
            exp_q.push_back(v);
        end
        if (upd_ok) m_tree[upd_set] = m_upd(m_tree[upd_set], upd_way);
`ifdef COMMON_CELLS_PLRU_AUTO_TOUCH_EN
        if (fire && !v[RW-1]) m_tree[lkp_set] = m_upd(t, v[1:0]);
`endif
        if (busy) begin
            m_tree[NS - m_left] = 3'b000;
            m_left--;
        end else if (flush) begin
            m_left = NS;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        upd_v   = 1'b0;
        lkp_v   = 1'b0;
        flush   = 1'b0;
        vic_rdy = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic do_update(input int s, input int w);
        upd_v   = 1'b1;
        upd_set = SW'(s);
        upd_way = WW'(w);
        cycle();
        upd_v   = 1'b0;
    endtask

    task automatic do_lookup(input int s, input logic [NW-1:0] lk);
        lkp_v   = 1'b1;
        lkp_set = SW'(s);
        lock    = lk;
        cycle();
        lkp_v   = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(victim_valid_o), 32'd0);
        check("rst_way", 32'(victim_way_o), 32'd0);
        check("rst_oh", 32'(victim_oh_o), 32'd0);
        check("rst_none", 32'(victim_none_o), 32'd0);
        check("rst_busy", 32'(flush_busy_o), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // First lookup after reset, then the update/lock/bypass scenarios.
        do_lookup(3, 4'b0000);
        idle(1);
        for (int w = 0; w < NW; w++) do_update(2, w);
        do_lookup(2, 4'b0000);
        do_lookup(5, 4'b0000);
        do_lookup(1, 4'b0011);
        do_lookup(1, 4'b1111);
        upd_v = 1'b1; upd_set = 3'd4; upd_way = 2'd0;
        do_lookup(4, 4'b0000);
        upd_v = 1'b0;
        idle(1);
        do_lookup(0, 4'b0000);
        do_lookup(0, 4'b0000);
        idle(1);

        // Consumer stall for three cycles, then release with a waiting lookup.
        do_lookup(6, 4'b0000);
        vic_rdy = 1'b0;
        lkp_v = 1'b1; lkp_set = 3'd7; lock = 4'b0100;
        repeat (3) cycle();
        vic_rdy = 1'b1;
        cycle();
        do_lookup(7, 4'b1000);
        idle(2);

        // Dirty every set, then flush with a buffered result and a repeated flush pulse.
        for (int s = 0; s < NS; s++) do_update(s, $urandom_range(0, NW - 1));
        for (int s = 0; s < NS; s++) do_update(s, $urandom_range(0, NW - 1));
        vic_rdy = 1'b0;
        do_lookup(2, 4'b0000);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            flush   = (i == 3);
            vic_rdy = (i >= 2);
            upd_v   = 1'(($urandom_range(0, 1)));
            upd_set = SW'($urandom_range(0, NS - 1));
            upd_way = WW'($urandom_range(0, NW - 1));
            lkp_v   = (i >= 5);
            lkp_set = SW'($urandom_range(0, NS - 1));
            lock    = 4'b0000;
            busy_cnt += int'(flush_busy_o);
            cycle();
        end
        check("flush_busy_cycles", 32'(busy_cnt), 32'd8);
        idle(2);
        for (int s = 0; s < NS; s++) do_lookup(s, 4'b0000);
        idle(2);

        // Reset in the middle of a sweep.
        for (int s = 0; s < NS; s++) do_update(s, 3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midsweep_rst_busy", 32'(flush_busy_o), 32'd0);
        check("midsweep_rst_valid", 32'(victim_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) do_lookup(s, 4'b0000);
        idle(1);

        // Random mix of updates, locked lookups, back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            upd_v   = 1'(($urandom_range(0, 1)));
            upd_set = SW'($urandom_range(0, NS - 1));
            upd_way = WW'($urandom_range(0, NW - 1));
            lkp_v   = 1'(($urandom_range(0, 1)));
            lkp_set = SW'($urandom_range(0, NS - 1));
            lock    = ($urandom_range(0, 7) == 0) ? 4'hF : NW'($urandom_range(0, 15));
            vic_rdy = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 80) == 0);
            cycle();
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
